alu_control_mc: RTL and testbench
=================================

# alu_control_mc

Multi-cycle successor to the single-cycle ALU control decoder. It decodes ALUOp plus the instruction function field into the 4-bit ALU control code, with an extended op set. Multiply and divide ops are not sent to the combinational ALU: this block executes them iteratively on WIDTH-bit operands and returns HI/LO through a valid/ready handshake. It sits between the main control unit and the EX stage; md_busy drives the pipeline stall logic.

## Interface
- WIDTH, 32: operand and result width, >= 4.
- SIGNED_EN, 1: 0 decodes MULT/DIV as MULTU/DIVU.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_op  in  2  ALUOp from main control.
- funct  in  6  instruction function field.
- alu_control  out  4  decoded ALU control code, combinational.
- in_valid  in  1  operands and op valid; only mul/div ops start the FSM.
- in_ready  out  1  iterative unit can accept.
- operand_a, operand_b  in  WIDTH  dividend/multiplicand, divisor/multiplier.
- flush  in  1  synchronous abort of an in-flight op.
- out_valid  out  1  HI/LO result valid.
- out_ready  in  1  consumer accepts the result.
- out_hi, out_lo  out  WIDTH  product high/low, or remainder/quotient.
- div_by_zero  out  1  qualifies the current result.
- md_busy  out  1  state != IDLE.

## Operation
- Decode, for any alu_op/funct:
  - 00 -> 0010 add.
  - 01 -> 0110 sub.
  - 11 -> 0010 (reserved).
  - 10 with funct:
    - 100000 add 0010; 100010 sub 0110; 100100 and 0000; 100101 or 0001.
    - 100110 xor 0011; 100111 nor 1100; 101010 slt 0111; 101011 sltu 0100.
    - 011000 mult 1000; 011001 multu 1010; 011010 div 1001; 011011 divu 1011.
    - Any other funct -> 0010.
- An op is mul/div when alu_control is 10xx.
- FSM states and transitions:
  - IDLE: on accept of a mul/div op, go to MUL or DIV.
  - MUL, DIV: on count == WIDTH-1, go to FIX.
  - FIX: go to DONE.
  - DONE: on out_ready, go to IDLE, or straight to MUL/DIV on a simultaneous accept.
- Accept rule: in_valid && in_ready && mul/div op. The accept edge latches the operands, the op and the operand signs.
- in_ready = (state == IDLE) || (state == DONE && out_ready).
- Multiply: shift-add over |a| and |b|, one bit per cycle, WIDTH cycles, 2*WIDTH accumulator. FIX negates the 2*WIDTH product if the signs differ (signed op only).
- Divide: restoring division over magnitudes, one quotient bit per cycle, WIDTH cycles. In FIX, for signed ops:
  - quotient is negated if the signs differ;
  - remainder takes the dividend's sign.
- Divide by zero is detected at accept:
  - go directly to DONE on the next edge;
  - out_hi = operand_a, out_lo = all ones, div_by_zero = 1.
- Most-negative / -1 (signed): out_lo = most-negative, out_hi = 0, with no flag.
- Non-mul/div ops with in_valid have no sequential effect.

## Timing
- Reset values: state IDLE, out_valid 0, out_hi 0, out_lo 0, div_by_zero 0, md_busy 0, in_ready 1.
- Latency: out_valid rises after the (WIDTH+1)th rising edge following the accept edge (33 for WIDTH=32). Divide by zero takes 1 edge.
- out_valid, out_hi, out_lo and div_by_zero hold stable while out_valid && !out_ready.
- out_hi and out_lo keep their last value after the handshake until the next result.
- div_by_zero clears on the next accept.
- flush:
  - takes priority over everything except reset;
  - next edge goes to IDLE and drops out_valid;
  - out_hi and out_lo are unchanged;
  - a same-cycle in_valid is not accepted.
- rst_n low mid-operation: immediate return to the reset values; the partial result is discarded.

## Structure
- Package alu_ctrl_pkg holds:
  - ALUOp encodings, funct encodings and ALU control codes as named constants;
  - the FSM state enum.
- Sub-module alu_op_decode: pure combinational alu_op/funct -> alu_control plus is_mul, is_div and is_signed. It is instantiated here and reusable by the hazard unit.

## Test plan
- Decode sweep: every alu_op × funct pair -> the codes listed above; funct 000000 with alu_op 10 -> 0010.
- MULT, WIDTH=32: a=0xFFFFFFFD, b=7 -> out_hi=0xFFFFFFFF, out_lo=0xFFFFFFEB. out_valid 33 edges after accept; md_busy high throughout.
- MULTU: a=0xFFFFFFFF, b=2 -> out_hi=0x00000001, out_lo=0xFFFFFFFE.
- DIV: a=-7, b=2 -> out_lo=0xFFFFFFFD, out_hi=0xFFFFFFFF. DIVU: a=0xFFFFFFF9, b=2 -> out_lo=0x7FFFFFFC, out_hi=1.
- DIV by zero: a=5, b=0 -> 1 edge later out_valid=1, out_hi=5, out_lo=0xFFFFFFFF, div_by_zero=1.
- Back-pressure and abort:
  - out_ready low 10 cycles: result held, in_ready low.
  - out_ready plus new in_valid in DONE: back-to-back accept.
  - flush at cycle 12: IDLE next edge, no out_valid.
  - rst_n low mid-divide: all outputs go to their reset values.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control decoder and the iterative mul/div unit:
// ALUOp encodings, R-type funct codes, ALU control codes and the FSM state enum.
package alu_ctrl_pkg;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_RSVD  = 2'b11;

   localparam logic [5:0] FUNCT_ADD   = 6'b100000;
   localparam logic [5:0] FUNCT_SUB   = 6'b100010;
   localparam logic [5:0] FUNCT_AND   = 6'b100100;
   localparam logic [5:0] FUNCT_OR    = 6'b100101;
   localparam logic [5:0] FUNCT_XOR   = 6'b100110;
   localparam logic [5:0] FUNCT_NOR   = 6'b100111;
   localparam logic [5:0] FUNCT_SLT   = 6'b101010;
   localparam logic [5:0] FUNCT_SLTU  = 6'b101011;
   localparam logic [5:0] FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

   localparam logic [3:0] ALUC_AND    = 4'b0000;
   localparam logic [3:0] ALUC_OR     = 4'b0001;
   localparam logic [3:0] ALUC_ADD    = 4'b0010;
   localparam logic [3:0] ALUC_XOR    = 4'b0011;
   localparam logic [3:0] ALUC_SLTU   = 4'b0100;
   localparam logic [3:0] ALUC_SUB    = 4'b0110;
   localparam logic [3:0] ALUC_SLT    = 4'b0111;
   localparam logic [3:0] ALUC_MULT   = 4'b1000;
   localparam logic [3:0] ALUC_DIV    = 4'b1001;
   localparam logic [3:0] ALUC_MULTU  = 4'b1010;
   localparam logic [3:0] ALUC_DIVU   = 4'b1011;
   localparam logic [3:0] ALUC_NOR    = 4'b1100;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_DIV  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } md_state_e;

endpackage

// File: rtl/alu_control_mc_if.sv
// Bus between main control / EX stage and the ALU control + mul/div block.
interface alu_control_mc_if #(parameter int WIDTH = 32) ();
   logic [1:0]       alu_op;
   logic [5:0]       funct;
   logic [3:0]       alu_control;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_hi;
   logic [WIDTH-1:0] out_lo;
   logic             div_by_zero;
   logic             md_busy;

   modport master (
      output alu_op, funct, in_valid, operand_a, operand_b, flush, out_ready,
      input  alu_control, in_ready, out_valid, out_hi, out_lo, div_by_zero, md_busy
   );

   modport slave (
      input  alu_op, funct, in_valid, operand_a, operand_b, flush, out_ready,
      output alu_control, in_ready, out_valid, out_hi, out_lo, div_by_zero, md_busy
   );
endinterface

// File: rtl/alu_op_decode.sv
// Pure combinational ALUOp/funct decoder; also flags mul/div ops and signedness
// so the hazard unit can reuse it without the iterative datapath.
module alu_op_decode
   import alu_ctrl_pkg::*;
#(
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output logic [3:0] alu_control,
   output logic       is_mul,
   output logic       is_div,
   output logic       is_signed
);

   // Map ALUOp/funct to the 4-bit control code; unknown encodings fall back to add.
   always_comb begin
      alu_control = ALUC_ADD;
      case (alu_op)
         ALUOP_ADD:  alu_control = ALUC_ADD;
         ALUOP_SUB:  alu_control = ALUC_SUB;
         ALUOP_RSVD: alu_control = ALUC_ADD;
         ALUOP_RTYPE: begin
            case (funct)
               FUNCT_ADD:   alu_control = ALUC_ADD;
               FUNCT_SUB:   alu_control = ALUC_SUB;
               FUNCT_AND:   alu_control = ALUC_AND;
               FUNCT_OR:    alu_control = ALUC_OR;
               FUNCT_XOR:   alu_control = ALUC_XOR;
               FUNCT_NOR:   alu_control = ALUC_NOR;
               FUNCT_SLT:   alu_control = ALUC_SLT;
               FUNCT_SLTU:  alu_control = ALUC_SLTU;
               FUNCT_MULT:  alu_control = SIGNED_EN ? ALUC_MULT : ALUC_MULTU;
               FUNCT_MULTU: alu_control = ALUC_MULTU;
               FUNCT_DIV:   alu_control = SIGNED_EN ? ALUC_DIV : ALUC_DIVU;
               FUNCT_DIVU:  alu_control = ALUC_DIVU;
               default:     alu_control = ALUC_ADD;
            endcase
         end
         default: alu_control = ALUC_ADD;
      endcase
   end

   // Mul/div live in the 10xx codes: bit0 selects divide, bit1 selects unsigned.
   assign is_mul    = (alu_control[3:2] == 2'b10) && !alu_control[0];
   assign is_div    = (alu_control[3:2] == 2'b10) &&  alu_control[0];
   assign is_signed = !alu_control[1];

endmodule

// File: rtl/alu_control_mc.sv
// ALU control decoder plus an iterative multiply/divide unit that returns HI/LO
// through a valid/ready handshake; md_busy feeds the pipeline stall logic.
module alu_control_mc
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   alu_control_mc_if.slave bus
);

   localparam int CW = $clog2(WIDTH);

   logic [3:0]         dec_ctrl_s;
   logic               is_mul_s, is_div_s, is_signed_s;
   logic               in_ready_s, accept_s, sign_a_s, sign_b_s;
   logic [WIDTH-1:0]   mag_a_s, mag_b_s;
   logic [WIDTH:0]     mul_sum_s, div_shift_s, div_diff_s;
   logic [2*WIDTH-1:0] mul_next_s, div_next_s, prod_s;
   logic [WIDTH-1:0]   quot_s, rem_s;

   md_state_e          state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;        // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0] acc_q, acc_d;          // {hi, lo} working register
   logic               op_mul_q, op_mul_d;
   logic               neg_res_q, neg_res_d;  // product / quotient sign fix-up
   logic               neg_rem_q, neg_rem_d;  // remainder follows dividend sign
   logic [WIDTH-1:0]   out_hi_q, out_hi_d, out_lo_q, out_lo_d;
   logic               out_valid_q, out_valid_d, dbz_q, dbz_d;

   alu_op_decode #(.SIGNED_EN(SIGNED_EN)) u_dec (
      .alu_op      (bus.alu_op),
      .funct       (bus.funct),
      .alu_control (dec_ctrl_s),
      .is_mul      (is_mul_s),
      .is_div      (is_div_s),
      .is_signed   (is_signed_s)
   );

   assign in_ready_s = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
   assign accept_s   = bus.in_valid && in_ready_s && (is_mul_s || is_div_s) && !bus.flush;
   assign sign_a_s   = is_signed_s && bus.operand_a[WIDTH-1];
   assign sign_b_s   = is_signed_s && bus.operand_b[WIDTH-1];
   assign mag_a_s    = sign_a_s ? -bus.operand_a : bus.operand_a;
   assign mag_b_s    = sign_b_s ? -bus.operand_b : bus.operand_b;

   // Shift-add step: multiplier bits sit in the low half and are consumed LSB first.
   assign mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                       (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
   assign mul_next_s = {mul_sum_s, acc_q[WIDTH-1:1]};

   // Restoring step: partial remainder in the high half, dividend/quotient in the low half.
   assign div_shift_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_diff_s  = div_shift_s - {1'b0, opnd_q};
   assign div_next_s  = div_diff_s[WIDTH] ? {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                          : {div_diff_s[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

   // Sign correction applied in FIX; most-negative / -1 wraps back to most-negative.
   assign prod_s = neg_res_q ? -acc_q : acc_q;
   assign quot_s = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_s  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

   // Next-state and datapath update; flush wins, an accept overrides the DONE exit.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      opnd_d      = opnd_q;
      acc_d       = acc_q;
      op_mul_d    = op_mul_q;
      neg_res_d   = neg_res_q;
      neg_rem_d   = neg_rem_q;
      out_hi_d    = out_hi_q;
      out_lo_d    = out_lo_q;
      out_valid_d = out_valid_q;
      dbz_d       = dbz_q;
      if (bus.flush) begin
         state_d     = ST_IDLE;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_MUL, ST_DIV: begin
               acc_d = (state_q == ST_MUL) ? mul_next_s : div_next_s;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_d = ST_FIX;
               end else begin
                  state_d = state_q;
               end
            end
            ST_FIX: begin
               if (op_mul_q) begin
                  out_hi_d = prod_s[2*WIDTH-1:WIDTH];
                  out_lo_d = prod_s[WIDTH-1:0];
               end else begin
                  out_hi_d = rem_s;
                  out_lo_d = quot_s;
               end
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  out_valid_d = 1'b0;
                  state_d     = ST_IDLE;
               end else begin
                  state_d = ST_DONE;
               end
            end
            default: begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
            end
         endcase
         if (accept_s) begin
            op_mul_d  = is_mul_s;
            neg_res_d = sign_a_s ^ sign_b_s;
            neg_rem_d = sign_a_s;
            opnd_d    = is_mul_s ? mag_a_s : mag_b_s;
            acc_d     = {{WIDTH{1'b0}}, (is_mul_s ? mag_b_s : mag_a_s)};
            cnt_d     = '0;
            dbz_d     = 1'b0;
            if (is_div_s && (bus.operand_b == '0)) begin
               state_d     = ST_DONE;
               out_hi_d    = bus.operand_a;
               out_lo_d    = '1;
               dbz_d       = 1'b1;
               out_valid_d = 1'b1;
            end else begin
               state_d     = is_mul_s ? ST_MUL : ST_DIV;
               out_valid_d = 1'b0;
            end
         end else begin
            op_mul_d = op_mul_q;
         end
      end
   end

   // State and result registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         opnd_q      <= '0;
         acc_q       <= '0;
         op_mul_q    <= 1'b0;
         neg_res_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         out_hi_q    <= '0;
         out_lo_q    <= '0;
         out_valid_q <= 1'b0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         opnd_q      <= opnd_d;
         acc_q       <= acc_d;
         op_mul_q    <= op_mul_d;
         neg_res_q   <= neg_res_d;
         neg_rem_q   <= neg_rem_d;
         out_hi_q    <= out_hi_d;
         out_lo_q    <= out_lo_d;
         out_valid_q <= out_valid_d;
         dbz_q       <= dbz_d;
      end
   end

   assign bus.alu_control = dec_ctrl_s;
   assign bus.in_ready    = in_ready_s;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_hi      = out_hi_q;
   assign bus.out_lo      = out_lo_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.md_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_control_mc.sv
// Directed bench for alu_control_mc: decode sweep, mul/div results through a
// scoreboard, latency, back-pressure, back-to-back accept, flush and reset.
module tb_alu_control_mc;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_control_mc_if #(.WIDTH(32)) bus ();

   alu_control_mc #(.WIDTH(32), .SIGNED_EN(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every result handshake pops the oldest expectation and compares it.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got hi=0x%0h lo=0x%0h, expected no result",
                     bus.out_hi, bus.out_lo);
         end else begin
            e = sb_q.pop_front();
            check({e.name, "_hi"},  bus.out_hi,      e.hi);
            check({e.name, "_lo"},  bus.out_lo,      e.lo);
            check({e.name, "_dbz"}, bus.div_by_zero, e.dbz);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [5:0] f);
      case (op)
         2'b00: return 4'b0010;
         2'b01: return 4'b0110;
         2'b11: return 4'b0010;
         default: begin
            case (f)
               6'b100000: return 4'b0010;
               6'b100010: return 4'b0110;
               6'b100100: return 4'b0000;
               6'b100101: return 4'b0001;
               6'b100110: return 4'b0011;
               6'b100111: return 4'b1100;
               6'b101010: return 4'b0111;
               6'b101011: return 4'b0100;
               6'b011000: return 4'b1000;
               6'b011001: return 4'b1010;
               6'b011010: return 4'b1001;
               6'b011011: return 4'b1011;
               default:   return 4'b0010;
            endcase
         end
      endcase
   endfunction

   // Present an op, wait (bounded) for in_ready, and leave the task just after the accept edge.
   task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [31:0] eh, input logic [31:0] el,
                        input logic ed, input string nm);
      int w;
      exp_t e;
      bus.alu_op    = 2'b10;
      bus.funct     = f;
      bus.operand_a = a;
      bus.operand_b = b;
      bus.in_valid  = 1'b1;
      w = 0;
      while (!bus.in_ready && w < 100) begin
         tick();
         w++;
      end
      check({nm, "_in_ready_wait"}, (w < 100), 1'b1);
      if (push) begin
         e.hi = eh; e.lo = el; e.dbz = ed; e.name = nm;
         sb_q.push_back(e);
      end
      tick();
      bus.in_valid = 1'b0;
      bus.alu_op   = 2'b00;
      bus.funct    = 6'b000000;
   endtask

   task automatic wait_valid(input int max, output int n, output bit busy_all);
      n = 0;
      busy_all = bus.md_busy;
      while (!bus.out_valid && n < max) begin
         tick();
         n++;
         busy_all = busy_all & bus.md_busy;
      end
   endtask

   task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic ed,
                         input int lat, input string nm);
      int  n;
      bit  busy;
      issue(f, a, b, 1'b1, eh, el, ed, nm);
      wait_valid(60, n, busy);
      check({nm, "_latency"}, n, lat);
      check({nm, "_md_busy"}, busy, 1'b1);
      tick();
      check({nm, "_valid_drop"}, bus.out_valid, 1'b0);
   endtask

   initial begin
      int  n;
      bit  busy, quiet;
      int  w;

      rst_n         = 1'b0;
      bus.alu_op    = 2'b00;
      bus.funct     = 6'b000000;
      bus.in_valid  = 1'b0;
      bus.operand_a = 32'h0;
      bus.operand_b = 32'h0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) tick();

      check("rst_out_valid", bus.out_valid,   1'b0);
      check("rst_out_hi",    bus.out_hi,      32'h0);
      check("rst_out_lo",    bus.out_lo,      32'h0);
      check("rst_dbz",       bus.div_by_zero, 1'b0);
      check("rst_md_busy",   bus.md_busy,     1'b0);
      check("rst_in_ready",  bus.in_ready,    1'b1);
      rst_n = 1'b1;
      tick();

      for (int o = 0; o < 4; o++) begin
         for (int f = 0; f < 64; f++) begin
            bus.alu_op = 2'(o);
            bus.funct  = 6'(f);
            #1;
            check($sformatf("decode_op%0d_f%02h", o, f), bus.alu_control, ref_ctrl(2'(o), 6'(f)));
         end
      end
      bus.alu_op = 2'b10;
      bus.funct  = 6'b000000;
      #1;
      check("decode_rtype_f00", bus.alu_control, 4'b0010);
      bus.alu_op = 2'b00;
      tick();

      run_op(6'b011000, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, "mult");
      run_op(6'b011001, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0, 33, "multu");
      run_op(6'b011010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, "div");
      run_op(6'b011011, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 1'b0, 33, "divu");
      run_op(6'b011010, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1, 0,  "div0");
      run_op(6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, "minneg");

      // Back-pressure: result must hold and in_ready stay low while out_ready is low.
      bus.out_ready = 1'b0;
      issue(6'b011000, 32'h00000003, 32'h00000005, 1'b1, 32'h0, 32'h0000000F, 1'b0, "bp_mult");
      wait_valid(60, n, busy);
      check("bp_latency", n, 33);
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("bp_hold_valid_%0d", i), bus.out_valid, 1'b1);
         check($sformatf("bp_hold_lo_%0d", i),    bus.out_lo,    32'h0000000F);
         check($sformatf("bp_hold_hi_%0d", i),    bus.out_hi,    32'h0);
         check($sformatf("bp_in_ready_%0d", i),   bus.in_ready,  1'b0);
      end

      // Back-to-back: release the result and accept a new op on the same edge.
      bus.out_ready = 1'b1;
      #1;
      check("b2b_in_ready", bus.in_ready, 1'b1);
      issue(6'b011011, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0, "b2b_divu");
      check("b2b_valid_low", bus.out_valid, 1'b0);
      check("b2b_busy",      bus.md_busy,   1'b1);
      wait_valid(60, n, busy);
      check("b2b_latency", n, 33);
      tick();

      // Flush at cycle 12 of a multiply, with a competing in_valid that must be ignored.
      issue(6'b011000, 32'd9, 32'd9, 1'b0, 32'h0, 32'h0, 1'b0, "flush_mult");
      repeat (11) tick();
      bus.flush     = 1'b1;
      bus.alu_op    = 2'b10;
      bus.funct     = 6'b011001;
      bus.operand_a = 32'd4;
      bus.operand_b = 32'd4;
      bus.in_valid  = 1'b1;
      tick();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      bus.alu_op   = 2'b00;
      check("flush_busy",   bus.md_busy,   1'b0);
      check("flush_valid",  bus.out_valid, 1'b0);
      check("flush_hi",     bus.out_hi,    32'd2);
      check("flush_lo",     bus.out_lo,    32'd14);
      quiet = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         quiet = quiet & !bus.out_valid & !bus.md_busy;
      end
      check("flush_quiet", quiet, 1'b1);

      // Asynchronous reset in the middle of a divide.
      issue(6'b011010, 32'd100, 32'd3, 1'b0, 32'h0, 32'h0, 1'b0, "rst_div");
      repeat (10) tick();
      check("pre_rst_busy", bus.md_busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", bus.out_valid,   1'b0);
      check("midrst_out_hi",    bus.out_hi,      32'h0);
      check("midrst_out_lo",    bus.out_lo,      32'h0);
      check("midrst_dbz",       bus.div_by_zero, 1'b0);
      check("midrst_md_busy",   bus.md_busy,     1'b0);
      check("midrst_in_ready",  bus.in_ready,    1'b1);
      tick();
      rst_n = 1'b1;
      tick();

      run_op(6'b011001, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 33, "post_rst_multu");

      w = 0;
      while (sb_q.size() != 0 && w < 100) begin
         tick();
         w++;
      end
      check("scoreboard_empty", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
